// File: rtl/lane_density_estimator.sv
// Per-approach vehicle density estimator: synchronise, debounce and edge-detect four
// detector inputs, count vehicles over a fixed window, publish saturated 4-bit densities.
module lane_density_estimator #(
  parameter int         WINDOW_CYCLES = 128,
  parameter int         DEBOUNCE      = 3,
  parameter int         SHIFT         = 0,
  parameter int         SMOOTH        = 0,
  parameter logic [3:0] INIT_DENSITY  = 4'd8
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic       en,
  input  logic       veh_n,
  input  logic       veh_s,
  input  logic       veh_e,
  input  logic       veh_w,
  output logic [3:0] density_n,
  output logic [3:0] density_s,
  output logic [3:0] density_e,
  output logic [3:0] density_w,
  output logic       density_valid
);

  localparam logic [3:0]  DEB_LAST = 4'(DEBOUNCE - 1);
  localparam logic [15:0] WIN_LAST = 16'(WINDOW_CYCLES - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'd255) ? cnt : cnt + 8'd1;
  endfunction

  function automatic logic [3:0] sat_scale(input logic [7:0] cnt);
    logic [7:0] sh;
    sh = cnt >> SHIFT;
    return (sh > 8'd15) ? 4'd15 : sh[3:0];
  endfunction

  // Round-half-up average; the 5-bit sum keeps 15+15+1 without overflow.
  function automatic logic [3:0] smooth_avg(input logic [3:0] prev, input logic [3:0] nxt);
    logic [4:0] sum;
    sum = {1'b0, prev} + {1'b0, nxt} + 5'd1;
    return sum[4:1];
  endfunction

  logic [3:0]  veh_raw;
  logic [3:0]  sync_p0;
  logic [3:0]  sync_p1;
  logic [3:0]  deb_p2;
  logic [3:0]  deb_d_p3;
  logic [3:0]  deb_cnt [4];
  logic [7:0]  veh_cnt [4];
  logic [3:0]  density [4];
  logic [15:0] win_cnt;
  logic [3:0]  veh_evt;
  logic        terminal;
  logic [7:0]  eff_cnt [4];
  logic [3:0]  dens_next [4];

  assign veh_raw  = {veh_w, veh_e, veh_s, veh_n};
  assign veh_evt  = deb_p2 & ~deb_d_p3;
  assign terminal = en && (win_cnt == WIN_LAST);

  // Terminal-edge view: an event on the terminal edge still belongs to this window.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      eff_cnt[i]   = veh_evt[i] ? sat_inc(veh_cnt[i]) : veh_cnt[i];
      dens_next[i] = (SMOOTH != 0) ? smooth_avg(density[i], sat_scale(eff_cnt[i]))
                                   : sat_scale(eff_cnt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_a) begin
      sync_p0       <= '0;
      sync_p1       <= '0;
      deb_p2        <= '0;
      deb_d_p3      <= '0;
      win_cnt       <= '0;
      density_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        deb_cnt[i] <= '0;
        veh_cnt[i] <= '0;
        density[i] <= INIT_DENSITY;
      end
    end else begin
      // p0/p1: two-flop synchroniser; p2: debounced level; p3: edge-detect delay
      sync_p0       <= veh_raw;
      sync_p1       <= sync_p0;
      deb_d_p3      <= deb_p2;
      density_valid <= terminal;
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == deb_p2[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_p2[i]  <= sync_p1[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 4'd1;
        end
      end
      if (en) begin
        if (terminal) begin
          win_cnt <= '0;
          for (int i = 0; i < 4; i++) begin
            veh_cnt[i] <= '0;
            density[i] <= dens_next[i];
          end
        end else begin
          win_cnt <= win_cnt + 16'd1;
          for (int i = 0; i < 4; i++) begin
            if (veh_evt[i]) veh_cnt[i] <= sat_inc(veh_cnt[i]);
          end
        end
      end
    end
  end

  assign density_n = density[0];
  assign density_s = density[1];
  assign density_e = density[2];
  assign density_w = density[3];

endmodule

// File: tb/tb_lane_density_estimator.sv
// Directed bench for lane_density_estimator: a default instance plus SHIFT=1 and SMOOTH=1
// instances sharing one stimulus stream, checked window by window against hand values.
module tb_lane_density_estimator;

  localparam int WIN = 128;

  typedef struct {
    int start;
    int cnt;
    int hi;
    int lo;
  } pat_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic en = 1'b1;
  logic veh_n = 1'b0, veh_s = 1'b0, veh_e = 1'b0, veh_w = 1'b0;
  logic [3:0] d0_n, d0_s, d0_e, d0_w;
  logic [3:0] d1_n, d1_s, d1_e, d1_w;
  logic [3:0] d2_n, d2_s, d2_e, d2_w;
  logic v0, v1, v2;
  logic [3:0] cur_n, cur_s, cur_e, cur_w;
  int checks = 0;
  int errors = 0;
  pat_t idle;

  lane_density_estimator #(.WINDOW_CYCLES(WIN), .DEBOUNCE(3), .SHIFT(0), .SMOOTH(0)) dut_dflt (
    .clk(clk), .rst_a(rst_a), .en(en),
    .veh_n(veh_n), .veh_s(veh_s), .veh_e(veh_e), .veh_w(veh_w),
    .density_n(d0_n), .density_s(d0_s), .density_e(d0_e), .density_w(d0_w),
    .density_valid(v0));

  lane_density_estimator #(.WINDOW_CYCLES(WIN), .DEBOUNCE(3), .SHIFT(1), .SMOOTH(0)) dut_shift (
    .clk(clk), .rst_a(rst_a), .en(en),
    .veh_n(veh_n), .veh_s(veh_s), .veh_e(veh_e), .veh_w(veh_w),
    .density_n(d1_n), .density_s(d1_s), .density_e(d1_e), .density_w(d1_w),
    .density_valid(v1));

  lane_density_estimator #(.WINDOW_CYCLES(WIN), .DEBOUNCE(3), .SHIFT(0), .SMOOTH(1)) dut_smooth (
    .clk(clk), .rst_a(rst_a), .en(en),
    .veh_n(veh_n), .veh_s(veh_s), .veh_e(veh_e), .veh_w(veh_w),
    .density_n(d2_n), .density_s(d2_s), .density_e(d2_e), .density_w(d2_w),
    .density_valid(v2));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic pat_t mk(input int start, input int cnt, input int hi, input int lo);
    pat_t p;
    p.start = start;
    p.cnt   = cnt;
    p.hi    = hi;
    p.lo    = lo;
    return p;
  endfunction

  function automatic logic lvl(input int c, input pat_t p);
    int per;
    int rel;
    if (p.cnt == 0 || c < p.start) return 1'b0;
    per = p.hi + p.lo;
    rel = c - p.start;
    return ((rel / per) < p.cnt) && ((rel % per) < p.hi);
  endfunction

  task automatic chk_stable(input string tag);
    chk({tag, "_hold_n"}, d0_n, cur_n);
    chk({tag, "_hold_s"}, d0_s, cur_s);
    chk({tag, "_hold_e"}, d0_e, cur_e);
    chk({tag, "_hold_w"}, d0_w, cur_w);
  endtask

  task automatic publish(input string tag, input logic [3:0] n, input logic [3:0] s,
                         input logic [3:0] e, input logic [3:0] w);
    chk({tag, "_n"}, d0_n, n);
    chk({tag, "_s"}, d0_s, s);
    chk({tag, "_e"}, d0_e, e);
    chk({tag, "_w"}, d0_w, w);
    cur_n = n;
    cur_s = s;
    cur_e = e;
    cur_w = w;
  endtask

  task automatic do_reset(input string tag, input int cycles);
    rst_a = 1'b1;
    en    = 1'b1;
    veh_n = 1'b0; veh_s = 1'b0; veh_e = 1'b0; veh_w = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      chk({tag, "_rst_valid"}, v0, 1'b0);
      chk({tag, "_rst_n"}, d0_n, 4'd8);
      chk({tag, "_rst_s"}, d0_s, 4'd8);
      chk({tag, "_rst_e"}, d0_e, 4'd8);
      chk({tag, "_rst_w"}, d0_w, 4'd8);
      chk({tag, "_rst_shift_n"}, d1_n, 4'd8);
      chk({tag, "_rst_smooth_n"}, d2_n, 4'd8);
    end
    rst_a = 1'b0;
    cur_n = 4'd8; cur_s = 4'd8; cur_e = 4'd8; cur_w = 4'd8;
  endtask

  // Runs n_iter enabled cycles of a window; optional en-low pause before enabled cycle pause_at.
  task automatic run_window(input string tag, input pat_t pn, input pat_t ps, input pat_t pe,
                            input pat_t pw, input int n_iter, input int pause_at,
                            input int pause_len);
    for (int c = 0; c < n_iter; c++) begin
      if (c == pause_at) begin
        for (int p = 0; p < pause_len; p++) begin
          en = 1'b0;
          veh_n = 1'b0; veh_s = 1'b0; veh_e = 1'b0; veh_w = 1'b0;
          tick();
          chk({tag, "_pause_valid"}, v0, 1'b0);
          chk_stable({tag, "_pause"});
        end
      end
      en    = 1'b1;
      veh_n = lvl(c, pn);
      veh_s = lvl(c, ps);
      veh_e = lvl(c, pe);
      veh_w = lvl(c, pw);
      tick();
      if (c == WIN - 1) begin
        chk({tag, "_valid"}, v0, 1'b1);
        chk({tag, "_valid_shift"}, v1, 1'b1);
        chk({tag, "_valid_smooth"}, v2, 1'b1);
      end else begin
        chk({tag, "_idle_valid"}, v0, 1'b0);
        chk_stable(tag);
      end
    end
    veh_n = 1'b0; veh_s = 1'b0; veh_e = 1'b0; veh_w = 1'b0;
  endtask

  initial begin
    idle = mk(0, 0, 1, 1);

    // Reset, then an empty first window
    do_reset("t1", 3);
    run_window("t1", idle, idle, idle, idle, WIN, -1, 0);
    publish("t1", 4'd0, 4'd0, 4'd0, 4'd0);
    chk("t1_shift_n", d1_n, 4'd0);

    // Clean counting on north and south
    run_window("t2", mk(0, 5, 4, 4), mk(0, 11, 4, 4), idle, idle, WIN, -1, 0);
    publish("t2", 4'd5, 4'd11, 4'd0, 4'd0);
    chk("t2_shift_n", d1_n, 4'd2);
    chk("t2_shift_s", d1_s, 4'd5);

    // Glitch rejection: 2-cycle pulses vanish, 3-cycle pulses count
    run_window("t3", mk(0, 10, 2, 4), idle, idle, mk(0, 10, 3, 3), WIN, -1, 0);
    publish("t3", 4'd0, 4'd0, 4'd0, 4'd10);
    chk("t3_shift_w", d1_w, 4'd5);

    // Saturation at 15 and scaling by SHIFT=1
    run_window("t4", idle, idle, mk(0, 20, 3, 3), idle, WIN, -1, 0);
    publish("t4", 4'd0, 4'd0, 4'd15, 4'd0);
    chk("t4_shift_e", d1_e, 4'd10);

    // Last north event lands exactly on the terminal edge
    run_window("t6b", mk(106, 3, 4, 4), idle, idle, idle, WIN, -1, 0);
    publish("t6b", 4'd3, 4'd0, 4'd0, 4'd0);
    chk("t6b_shift_n", d1_n, 4'd1);
    run_window("t6b_next", idle, idle, idle, idle, WIN, -1, 0);
    publish("t6b_next", 4'd0, 4'd0, 4'd0, 4'd0);

    // en low for 40 cycles mid-window
    run_window("t6a", mk(0, 10, 4, 4), idle, idle, idle, WIN, 64, 40);
    publish("t6a", 4'd10, 4'd0, 4'd0, 4'd0);
    chk("t6a_shift_n", d1_n, 4'd5);

    // Reset at cycle 60 discards the partial window
    run_window("t6c", mk(0, 5, 4, 4), idle, idle, idle, 60, -1, 0);
    do_reset("t6c", 1);
    run_window("t6c_next", idle, idle, idle, idle, WIN, -1, 0);
    publish("t6c_next", 4'd0, 4'd0, 4'd0, 4'd0);

    // Smoothing from the reset value 8
    do_reset("t5", 2);
    run_window("t5a", mk(0, 3, 4, 4), idle, idle, idle, WIN, -1, 0);
    publish("t5a", 4'd3, 4'd0, 4'd0, 4'd0);
    chk("t5a_smooth_n", d2_n, 4'd6);
    chk("t5a_smooth_e", d2_e, 4'd4);
    run_window("t5b", mk(0, 15, 4, 4), idle, idle, idle, WIN, -1, 0);
    publish("t5b", 4'd15, 4'd0, 4'd0, 4'd0);
    chk("t5b_smooth_n", d2_n, 4'd11);
    chk("t5b_smooth_e", d2_e, 4'd2);
    run_window("t5c", idle, idle, idle, idle, WIN, -1, 0);
    publish("t5c", 4'd0, 4'd0, 4'd0, 4'd0);
    chk("t5c_smooth_n", d2_n, 4'd6);
    chk("t5c_smooth_e", d2_e, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
